// File: rtl/opf_stage_if.sv
// opf_stage_if: bundles the IF-side fields, GPR read ports, EX feedback,
// pipeline control and the registered ID outputs of the operand fetch stage.
interface opf_stage_if;
    // IF register fields
    logic        if_valid;
    logic [31:0] if_pc;
    logic [4:0]  if_ra_addr;
    logic [4:0]  if_rb_addr;
    logic        if_use_ra;
    logic        if_use_rb;
    logic [4:0]  if_rd_addr;
    logic        if_we;
    logic        if_load;

    // GPR read ports (data already includes WB write-through)
    logic [4:0]  gpr_rd_addr_0;
    logic [4:0]  gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0;
    logic [31:0] gpr_rd_data_1;

    // EX stage destination and result
    logic        ex_we;
    logic        ex_load;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_fwd_data;

    // Pipeline control
    logic        stall_in;
    logic        flush;
    logic        id_stall;

    // ID register outputs
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_ra_data;
    logic [31:0] id_rb_data;
    logic [4:0]  id_rd_addr;
    logic        id_we;
    logic        id_load;

    modport master (
        output if_valid, if_pc, if_ra_addr, if_rb_addr, if_use_ra, if_use_rb,
               if_rd_addr, if_we, if_load,
        output gpr_rd_data_0, gpr_rd_data_1,
        output ex_we, ex_load, ex_rd_addr, ex_fwd_data,
        output stall_in, flush,
        input  gpr_rd_addr_0, gpr_rd_addr_1, id_stall,
        input  id_valid, id_pc, id_ra_data, id_rb_data, id_rd_addr, id_we, id_load
    );

    modport slave (
        input  if_valid, if_pc, if_ra_addr, if_rb_addr, if_use_ra, if_use_rb,
               if_rd_addr, if_we, if_load,
        input  gpr_rd_data_0, gpr_rd_data_1,
        input  ex_we, ex_load, ex_rd_addr, ex_fwd_data,
        input  stall_in, flush,
        output gpr_rd_addr_0, gpr_rd_addr_1, id_stall,
        output id_valid, id_pc, id_ra_data, id_rb_data, id_rd_addr, id_we, id_load
    );
endinterface

// File: rtl/opf_stage.sv
// opf_stage: operand fetch into the ID register with EX dependency interlock.
// Build option OPF_FWD_EN: forward the EX result and stall only on load-use.
module opf_stage (
    input  logic       clk,
    input  logic       rst,
    opf_stage_if.slave bus
);
    logic        match_a;
    logic        match_b;
    logic        hazard;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign bus.gpr_rd_addr_0 = bus.if_ra_addr;
    assign bus.gpr_rd_addr_1 = bus.if_rb_addr;

    // Matches are gated by if_valid so an empty slot never stalls or forwards.
    always_comb begin
        match_a = bus.if_valid && bus.if_use_ra && bus.ex_we &&
                  (bus.if_ra_addr == bus.ex_rd_addr);
        match_b = bus.if_valid && bus.if_use_rb && bus.ex_we &&
                  (bus.if_rb_addr == bus.ex_rd_addr);
`ifdef OPF_FWD_EN
        hazard = bus.if_valid && (match_a || match_b) && bus.ex_load;
        op_a   = (match_a && !bus.ex_load) ? bus.ex_fwd_data : bus.gpr_rd_data_0;
        op_b   = (match_b && !bus.ex_load) ? bus.ex_fwd_data : bus.gpr_rd_data_1;
`else
        hazard = bus.if_valid && (match_a || match_b);
        op_a   = bus.gpr_rd_data_0;
        op_b   = bus.gpr_rd_data_1;
`endif
        bus.id_stall = !bus.flush && (bus.stall_in || hazard);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.id_valid   <= 1'b0;
            bus.id_we      <= 1'b0;
            bus.id_load    <= 1'b0;
            bus.id_pc      <= '0;
            bus.id_ra_data <= '0;
            bus.id_rb_data <= '0;
            bus.id_rd_addr <= '0;
        end else if (bus.flush) begin
            bus.id_valid <= 1'b0;
            bus.id_we    <= 1'b0;
            bus.id_load  <= 1'b0;
        end else if (bus.stall_in) begin
            bus.id_valid <= bus.id_valid;
        end else if (hazard) begin
            bus.id_valid <= 1'b0;
            bus.id_we    <= 1'b0;
            bus.id_load  <= 1'b0;
        end else begin
            bus.id_valid   <= bus.if_valid;
            bus.id_we      <= bus.if_we && bus.if_valid;
            bus.id_load    <= bus.if_load && bus.if_valid;
            bus.id_pc      <= bus.if_pc;
            bus.id_rd_addr <= bus.if_rd_addr;
            bus.id_ra_data <= op_a;
            bus.id_rb_data <= op_b;
        end
    end
endmodule

// File: tb/tb_opf_stage.sv
// tb_opf_stage: directed checks of the operand fetch stage (either build of OPF_FWD_EN).
module tb_opf_stage;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    opf_stage_if bus ();

    opf_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic [4:0] ra,
                          input logic [4:0] rb, input logic ua, input logic ub,
                          input logic [4:0] rd, input logic we, input logic ld);
        bus.if_valid   = v;
        bus.if_pc      = pc;
        bus.if_ra_addr = ra;
        bus.if_rb_addr = rb;
        bus.if_use_ra  = ua;
        bus.if_use_rb  = ub;
        bus.if_rd_addr = rd;
        bus.if_we      = we;
        bus.if_load    = ld;
    endtask

    task automatic set_ex(input logic we, input logic ld, input logic [4:0] rd,
                          input logic [31:0] data);
        bus.ex_we       = we;
        bus.ex_load     = ld;
        bus.ex_rd_addr  = rd;
        bus.ex_fwd_data = data;
    endtask

    initial begin
        rst = 1'b1;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        bus.gpr_rd_data_0 = 32'h0;
        bus.gpr_rd_data_1 = 32'h0;
        set_ex(1'b0, 1'b0, 5'd0, 32'h0);
        set_if(1'b1, 32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);

        // Reset with a valid instruction present
        #1;
        chk("rst_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("rst_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("rst_pc", bus.id_pc, 32'h0);
        chk("rst_ra", bus.id_ra_data, 32'h0);
        chk("rst_we", {31'b0, bus.id_we}, 32'd0);

        // Plain advance
        rst = 1'b0;
        set_if(1'b1, 32'h104, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        bus.gpr_rd_data_0 = 32'h11;
        bus.gpr_rd_data_1 = 32'h22;
        #1;
        chk("gpr_addr0", {27'b0, bus.gpr_rd_addr_0}, 32'd1);
        chk("gpr_addr1", {27'b0, bus.gpr_rd_addr_1}, 32'd2);
        chk("adv_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("adv_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("adv_pc", bus.id_pc, 32'h104);
        chk("adv_ra", bus.id_ra_data, 32'h11);
        chk("adv_rb", bus.id_rb_data, 32'h22);
        chk("adv_rd", {27'b0, bus.id_rd_addr}, 32'd7);
        chk("adv_we", {31'b0, bus.id_we}, 32'd1);
        chk("adv_load", {31'b0, bus.id_load}, 32'd0);

        // ALU dependency on EX
        set_ex(1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        set_if(1'b1, 32'h108, 5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        bus.gpr_rd_data_0 = 32'h1;
        bus.gpr_rd_data_1 = 32'h44;
        #1;
`ifdef OPF_FWD_EN
        chk("fwd_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("fwd_ra", bus.id_ra_data, 32'hDEADBEEF);
        chk("fwd_rb", bus.id_rb_data, 32'h44);
        chk("fwd_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("fwd_pc", bus.id_pc, 32'h108);
`else
        chk("nofwd_stall", {31'b0, bus.id_stall}, 32'd1);
        tick();
        chk("nofwd_bub_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("nofwd_bub_we", {31'b0, bus.id_we}, 32'd0);
        chk("nofwd_bub_pc", bus.id_pc, 32'h104);
        chk("nofwd_bub_ra", bus.id_ra_data, 32'h11);
        set_ex(1'b0, 1'b0, 5'd3, 32'hDEADBEEF);
        bus.gpr_rd_data_0 = 32'h33;
        #1;
        chk("nofwd_stall2", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("nofwd_ra", bus.id_ra_data, 32'h33);
        chk("nofwd_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("nofwd_pc", bus.id_pc, 32'h108);
`endif

        // Load-use on rb
        set_ex(1'b1, 1'b1, 5'd5, 32'h0BAD0BAD);
        set_if(1'b1, 32'h10C, 5'd6, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        bus.gpr_rd_data_0 = 32'h66;
        bus.gpr_rd_data_1 = 32'h99;
        #1;
        chk("lu_stall", {31'b0, bus.id_stall}, 32'd1);
        tick();
        chk("lu_bub_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("lu_bub_we", {31'b0, bus.id_we}, 32'd0);
        chk("lu_bub_pc", bus.id_pc, 32'h108);
        set_ex(1'b0, 1'b0, 5'd5, 32'h0BAD0BAD);
        bus.gpr_rd_data_1 = 32'h55;
        #1;
        chk("lu_stall2", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("lu_rb", bus.id_rb_data, 32'h55);
        chk("lu_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("lu_pc", bus.id_pc, 32'h10C);

        // Same load in EX but rb not used: no interlock
        set_ex(1'b1, 1'b1, 5'd5, 32'h0BAD0BAD);
        set_if(1'b1, 32'h110, 5'd6, 5'd5, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1);
        bus.gpr_rd_data_1 = 32'h66;
        #1;
        chk("unused_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("unused_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("unused_rb", bus.id_rb_data, 32'h66);
        chk("unused_load", {31'b0, bus.id_load}, 32'd1);
        chk("unused_pc", bus.id_pc, 32'h110);

        // Empty slot: matching register must not stall, controls gated off
        set_if(1'b0, 32'h114, 5'd5, 5'd5, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1);
        bus.gpr_rd_data_1 = 32'h77;
        #1;
        chk("inv_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("inv_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("inv_we", {31'b0, bus.id_we}, 32'd0);
        chk("inv_load", {31'b0, bus.id_load}, 32'd0);
        chk("inv_pc", bus.id_pc, 32'h114);
        chk("inv_rb", bus.id_rb_data, 32'h77);

        // flush beats stall_in and hazard
        set_if(1'b1, 32'h118, 5'd5, 5'd5, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        bus.flush    = 1'b1;
        bus.stall_in = 1'b1;
        #1;
        chk("prio_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("prio_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("prio_pc", bus.id_pc, 32'h114);

        // Load a known instruction, then hold it under stall_in
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0, 32'h0);
        set_if(1'b1, 32'h11C, 5'd8, 5'd9, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0);
        bus.gpr_rd_data_0 = 32'hA0;
        bus.gpr_rd_data_1 = 32'hB0;
        tick();
        chk("ld_valid", {31'b0, bus.id_valid}, 32'd1);
        chk("ld_pc", bus.id_pc, 32'h11C);
        chk("ld_rd", {27'b0, bus.id_rd_addr}, 32'd31);

        bus.stall_in = 1'b1;
        set_if(1'b1, 32'h200, 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1);
        bus.gpr_rd_data_0 = 32'hFF;
        bus.gpr_rd_data_1 = 32'hEE;
        #1;
        chk("hold_stall", {31'b0, bus.id_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", {31'b0, bus.id_valid}, 32'd1);
            chk("hold_pc", bus.id_pc, 32'h11C);
            chk("hold_ra", bus.id_ra_data, 32'hA0);
            chk("hold_rb", bus.id_rb_data, 32'hB0);
            chk("hold_rd", {27'b0, bus.id_rd_addr}, 32'd31);
            chk("hold_we", {31'b0, bus.id_we}, 32'd1);
            chk("hold_load", {31'b0, bus.id_load}, 32'd0);
        end

        // flush alone
        bus.stall_in = 1'b0;
        bus.flush    = 1'b1;
        #1;
        chk("flush_stall", {31'b0, bus.id_stall}, 32'd0);
        tick();
        chk("flush_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("flush_we", {31'b0, bus.id_we}, 32'd0);
        chk("flush_pc", bus.id_pc, 32'h11C);
        chk("flush_ra", bus.id_ra_data, 32'hA0);

        // r0 is an ordinary register for dependency purposes
        bus.flush = 1'b0;
        set_ex(1'b1, 1'b1, 5'd0, 32'h0);
        set_if(1'b1, 32'h120, 5'd0, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("r0_stall", {31'b0, bus.id_stall}, 32'd1);
        tick();
        chk("r0_valid", {31'b0, bus.id_valid}, 32'd0);

        // Reset overrides stall_in; id_stall is not gated by reset
        rst = 1'b1;
        bus.stall_in = 1'b1;
        set_ex(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("rst2_stall", {31'b0, bus.id_stall}, 32'd1);
        tick();
        chk("rst2_pc", bus.id_pc, 32'h0);
        chk("rst2_ra", bus.id_ra_data, 32'h0);
        chk("rst2_rb", bus.id_rb_data, 32'h0);
        chk("rst2_rd", {27'b0, bus.id_rd_addr}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/opf_stage.md
OPF_STAGE -- requirements
Module: opf_stage

Interface
REQ-001 SHALL have ports clk in 1 (clock) and rst in 1 (reset); one clock, reset is synchronous and active-high.
REQ-002 SHALL have if_valid in 1, if_pc in 32, if_ra_addr in 5, if_rb_addr in 5, if_use_ra in 1, if_use_rb in 1, if_rd_addr in 5, if_we in 1, if_load in 1: decoded instruction fields from IF register.
REQ-003 SHALL have gpr_rd_addr_0 out 5, gpr_rd_addr_1 out 5, gpr_rd_data_0 in 32, gpr_rd_data_1 in 32: GPR read ports; GPR read data already includes same-cycle WB write-through.
REQ-004 SHALL have ex_we in 1, ex_load in 1, ex_rd_addr in 5, ex_fwd_data in 32: EX-stage destination info and ALU result.
REQ-005 SHALL have stall_in in 1 (downstream freeze), flush in 1 (kill), id_stall out 1 (hold IF).
REQ-006 SHALL have registered outputs id_valid 1, id_pc 32, id_ra_data 32, id_rb_data 32, id_rd_addr 5, id_we 1, id_load 1.

Function
REQ-007 SHALL drive gpr_rd_addr_0 = if_ra_addr and gpr_rd_addr_1 = if_rb_addr combinationally.
REQ-008 SHALL define match_a = if_use_ra && ex_we && (if_ra_addr == ex_rd_addr); match_b likewise with rb; r0 gets no special treatment.
REQ-009 SHALL define hazard = if_valid && ((match_a || match_b) && ex_load) when forwarding compiled in (see REQ-019).
REQ-010 SHALL compute id_stall = !flush && (stall_in || hazard), combinationally.
REQ-011 SHALL select operand A = ex_fwd_data when match_a && !ex_load (forwarding enabled), else gpr_rd_data_0; operand B likewise.
REQ-012 SHALL update output registers on clk rising edge with priority: flush > stall_in > hazard > advance.
REQ-013 flush: id_valid, id_we, id_load <= 0; other id_* hold.
REQ-014 stall_in (no flush): all id_* hold their values.
REQ-015 hazard (no flush/stall_in): insert bubble: id_valid, id_we, id_load <= 0; other id_* hold; IF instruction held by id_stall and re-evaluated next cycle.
REQ-016 advance: id_valid <= if_valid; id_we <= if_we && if_valid; id_load <= if_load && if_valid; id_pc, id_rd_addr, id_ra_data, id_rb_data <= IF fields/selected operands; latency one cycle.
REQ-017 SHALL ignore all hazard/forward logic when if_valid = 0 (no stall generated).

Reset
REQ-018 SHALL on rst = 1 at clk edge clear id_valid, id_we, id_load to 0 and id_pc, id_ra_data, id_rb_data to 32'h0, id_rd_addr to 5'h0; rst overrides flush/stall; id_stall is combinational and not reset-gated.

Configuration
REQ-019 Macro OPF_FWD_EN: defined -> EX forwarding per REQ-011, hazard only on load-use (REQ-009); undefined -> no forwarding mux (operands always from GPR), hazard = if_valid && (match_a || match_b) regardless of ex_load, producing one bubble per EX dependency.

Verification
REQ-020 Reset: rst=1 one cycle with if_valid=1 -> after edge id_valid=0, id_pc=0, id_ra_data=0, id_stall follows REQ-010.
REQ-021 Forward (OPF_FWD_EN): ex_we=1, ex_load=0, ex_rd_addr=3, ex_fwd_data=32'hDEADBEEF, if_ra_addr=3, use_ra=1, gpr_rd_data_0=32'h1 -> next cycle id_ra_data=32'hDEADBEEF, id_valid=1, id_stall=0.
REQ-022 Load-use: ex_we=1, ex_load=1, ex_rd_addr=5, if_rb_addr=5, use_rb=1 -> id_stall=1, next id_valid=0; next cycle ex_we=0, gpr_rd_data_1=32'h55 -> id_rb_data=32'h55, id_valid=1.
REQ-023 Unused operand: as REQ-022 but use_rb=0 -> id_stall=0, no bubble, id_valid=1.
REQ-024 Priority: flush=1 and stall_in=1 with hazard -> id_stall=0, id_valid=0 next cycle; stall_in=1 alone -> all id_* unchanged for 3 cycles.
REQ-025 No-forward build (OPF_FWD_EN undefined): ex_we=1, ex_load=0, ex_rd_addr=3, if_ra_addr=3, use_ra=1 -> id_stall=1, one bubble, then id_ra_data=gpr_rd_data_0.
